// File: rtl/fp_pkg.sv
// Shared defaults, bias helper and result-flag layout for the fp_mul_pipe multiplier.
// Rounding mode is selected by FP_MUL_ROUND_EN (defined: nearest-even, undefined: truncate).
package fp_pkg;

  localparam int unsigned FP_EXP_W = 8;
  localparam int unsigned FP_MAN_W = 18;

  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_UNF  = 1;
  localparam int unsigned FLAG_ZERO = 0;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic zero;
  } fp_flags_t;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_norm_round.sv
// Combinational S3 of fp_mul_pipe: normalise, round, range-check and pack one product.
// FP_MUL_ROUND_EN selects round-to-nearest-even; otherwise discarded bits are truncated.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic                     sign,
  input  logic                     zero,
  input  logic signed [EXP_W+1:0]  exp_sum,
  input  logic [2*MAN_W+1:0]       prod,
  output logic [W-1:0]             res,
  output fp_flags_t                flags
);

  localparam int E_MAX_I = (1 << EXP_W) - 1;
  localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W+2)'(E_MAX_I);

  logic                    msb;
  logic [MAN_W-1:0]        man;
  logic [MAN_W:0]          man_rnd;
  logic signed [EXP_W+1:0] e_norm;
  logic signed [EXP_W+1:0] e_fin;

  assign msb    = prod[2*MAN_W+1];
  assign man    = msb ? prod[2*MAN_W:MAN_W+1] : prod[2*MAN_W-1:MAN_W];
  assign e_norm = exp_sum + $signed({{(EXP_W+1){1'b0}}, msb});

`ifdef FP_MUL_ROUND_EN
  logic guard;
  logic sticky;
  logic round_up;

  assign guard    = msb ? prod[MAN_W] : prod[MAN_W-1];
  assign sticky   = msb ? |prod[MAN_W-1:0] : |prod[MAN_W-2:0];
  assign round_up = guard & (sticky | man[0]);
  assign man_rnd  = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
`else
  logic discarded_unused;

  assign discarded_unused = ^prod[MAN_W-1:0];
  assign man_rnd          = {1'b0, man};
`endif

  // A rounding carry leaves the stored mantissa at zero, i.e. 1.0 at the next exponent.
  assign e_fin = e_norm + $signed({{(EXP_W+1){1'b0}}, man_rnd[MAN_W]});

  always_comb begin
    res   = '0;
    flags = '0;
    if (zero) begin
      res        = {sign, {(W-1){1'b0}}};
      flags.zero = 1'b1;
    end else if (e_fin > E_MAX) begin
      res       = {sign, {(W-1){1'b1}}};
      flags.ovf = 1'b1;
    end else if (e_fin[EXP_W+1] || (e_fin == E_MAX - E_MAX)) begin
      res        = {sign, {(W-1){1'b0}}};
      flags.unf  = 1'b1;
      flags.zero = 1'b1;
    end else begin
      res = {sign, e_fin[EXP_W-1:0], man_rnd[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage elastic floating-point multiplier (unpack / mantissa product / normalise-pack).
// Rounding is nearest-even when FP_MUL_ROUND_EN is defined, truncation otherwise.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] num1,
  input  logic [W-1:0] num2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic [2:0]   flags
);

  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'(fp_bias(EXP_W));

  logic run;
  logic v1, v2, v3;
  logic en1, en2, en3;

  logic [EXP_W-1:0] ea, eb;

  logic                    s1_sign, s1_zero;
  logic signed [EXP_W+1:0] s1_exp;
  logic [MAN_W:0]          s1_ma, s1_mb;

  logic                    s2_sign, s2_zero;
  logic signed [EXP_W+1:0] s2_exp;
  logic [2*MAN_W+1:0]      s2_prod;

  logic [W-1:0] nr_res;
  fp_flags_t    nr_flags;
  logic [W-1:0] s3_res;
  fp_flags_t    s3_flags;

  // Each stage loads when empty or when its content moves on; ready ripples back from out_ready.
  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign in_ready  = run && en1;
  assign out_valid = v3;
  assign res       = s3_res;
  assign flags     = s3_flags;

  assign ea = num1[W-2:MAN_W];
  assign eb = num2[W-2:MAN_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run     <= 1'b0;
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_exp  <= '0;
      s1_ma   <= '0;
      s1_mb   <= '0;
    end else begin
      run <= 1'b1;
      if (en1) begin
        v1      <= in_valid && in_ready;
        s1_sign <= num1[W-1] ^ num2[W-1];
        s1_zero <= (ea == '0) || (eb == '0);
        s1_exp  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
        s1_ma   <= {1'b1, num1[MAN_W-1:0]};
        s1_mb   <= {1'b1, num2[MAN_W-1:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_zero <= 1'b0;
      s2_exp  <= '0;
      s2_prod <= '0;
    end else if (en2) begin
      v2      <= v1;
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_exp  <= s1_exp;
      s2_prod <= s1_ma * s1_mb;
    end
  end

  fp_norm_round #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_norm_round (
    .sign    (s2_sign),
    .zero    (s2_zero),
    .exp_sum (s2_exp),
    .prod    (s2_prod),
    .res     (nr_res),
    .flags   (nr_flags)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v3       <= 1'b0;
      s3_res   <= '0;
      s3_flags <= '0;
    end else if (en3) begin
      v3       <= v2;
      s3_res   <= nr_res;
      s3_flags <= nr_flags;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe at default widths; tie-case expectation follows FP_MUL_ROUND_EN.
module tb_fp_mul_pipe;
  import fp_pkg::*;

  localparam int unsigned W = 27;
  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_OVF  = 3'(1 << FLAG_OVF);
  localparam logic [2:0] F_ZERO = 3'(1 << FLAG_ZERO);
  localparam logic [2:0] F_UNFZ = 3'((1 << FLAG_UNF) | (1 << FLAG_ZERO));
`ifdef FP_MUL_ROUND_EN
  localparam logic [W-1:0] TIE_RES = 27'h1FE0002;
`else
  localparam logic [W-1:0] TIE_RES = 27'h1FE0001;
`endif
  localparam logic [W-1:0] ONE = 27'h1FC0000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] num1 = '0;
  logic [W-1:0] num2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] res;
  logic [2:0]   flags;

  int errors = 0;
  int checks = 0;
  int sent, rcv;
  logic [W-1:0] held;
  logic [W-1:0] s_op [6];

  always #5 clk = ~clk;

  fp_mul_pipe #(
    .EXP_W(8),
    .MAN_W(18)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation: accept, then the result must appear on the third clock edge.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [2:0] ef);
    out_ready = 1'b1;
    num1 = a;
    num2 = b;
    in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_lat2"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_res"}, res, er);
    check({tag, "_flags"}, flags, ef);
  endtask

  initial begin
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_res", res, 0);
    check("rst_flags", flags, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("rel_in_ready_before_clk", in_ready, 0);
    @(posedge clk); #1;
    check("rel_in_ready_after_clk", in_ready, 1);

    do_op("mul_1p5", 27'h1FE0000, 27'h1FE0000, 27'h2008000, F_NONE);
    do_op("mul_neg", 27'h5FE0000, 27'h1FE0000, 27'h6008000, F_NONE);
    do_op("tie",     27'h1FC0001, 27'h1FE0000, TIE_RES,      F_NONE);
    do_op("ovf",     27'h3C00000, 27'h3C00000, 27'h3FFFFFF,  F_OVF);
    do_op("unf",     27'h0400000, 27'h0400000, 27'h0000000,  F_UNFZ);
    do_op("zero_a",  27'h0000000, 27'h1FC0000, 27'h0000000,  F_ZERO);
    do_op("zero_neg",27'h4000000, 27'h1FC0000, 27'h4000000,  F_ZERO);

    // Streaming: x * 1.0 returns x exactly; odd entries negative.
    for (int i = 0; i < 6; i++)
      s_op[i] = 27'h1FC0000 + 27'(i) * 27'h40000 + 27'(i) + ((i % 2 == 1) ? 27'h4000000 : 27'h0);
    sent = 0;
    rcv  = 0;
    held = '0;
    for (int c = 1; c <= 30 && rcv < 6; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = (sent < 6);
      num1      = s_op[(sent < 6) ? sent : 0];
      num2      = ONE;
      #1;
      if (c <= 9) check("stream_in_ready", in_ready, (c >= 4 && c <= 6) ? 0 : 1);
      if (c == 4) begin
        check("stream_held", sent - rcv, 3);
        held = res;
      end
      if (c == 5 || c == 6) begin
        check("stream_stall_valid", out_valid, 1);
        check("stream_stall_res", res, held);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check("stream_res", res, s_op[rcv]);
        rcv++;
      end
    end
    in_valid = 1'b0;
    check("stream_count", rcv, 6);
    @(posedge clk); #1;
    check("stream_no_extra", out_valid, 0);

    // Reset with two operations in flight.
    out_ready = 1'b1;
    num1 = 27'h1FE0000;
    num2 = 27'h1FE0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    num1 = 27'h5FE0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_res", res, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("mid_rel_in_ready_before_clk", in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("mid_rel_no_stale", out_valid, 0);
    end
    check("mid_rel_in_ready", in_ready, 1);
    do_op("post_rst", 27'h1FE0000, 27'h1FE0000, 27'h2008000, F_NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 18, stored mantissa width (hidden bit implicit); word width W = 1+EXP_W+MAN_W (27 by default), bias = 2^(EXP_W-1)-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 SHALL have ports num1 and num2  input  W  each a {sign, exponent, mantissa} operand.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port res  output  W  product.
REQ-011 SHALL have port flags  output  3  {ovf, unf, zero} for the result on res.

Function
REQ-012 SHALL transfer an input only when in_valid && in_ready, and an output only when out_valid && out_ready.
REQ-013 SHALL be a 3-stage elastic pipeline: S1 unpack, sign XOR, exponent sum; S2 (MAN_W+1)x(MAN_W+1) mantissa product; S3 normalise, round, range-check, pack.
REQ-014 SHALL have latency 3 cycles from accept to out_valid, and throughput 1 per cycle while out_ready=1.
REQ-015 SHALL advance each stage when it is empty or its successor advances; in_ready = S1 empty or S1 advancing (combinational from out_ready through the stage chain).
REQ-016 SHALL hold res, flags and out_valid stable while out_valid && !out_ready; no result may be dropped, duplicated or reordered.
REQ-017 SHALL treat an operand with exponent field 0 as zero (denormals flushed).
REQ-018 SHALL output {sign, 0...0} with zero=1 if either operand is zero; the product path is ignored.
REQ-019 SHALL compute the unbiased-corrected exponent e = ea+eb-bias in a signed EXP_W+2-bit value.
REQ-020 SHALL normalise as follows: if the product MSB (bit 2*MAN_W+1) is set, use mantissa = next MAN_W bits below it and e+1; otherwise use the MAN_W bits below bit 2*MAN_W.
REQ-021 SHALL, when e > 2^EXP_W-1 after rounding, output {sign, all-ones exponent, all-ones mantissa} (saturate, no Inf/NaN) with ovf=1.
REQ-022 SHALL, when e <= 0, output {sign, 0...0} with unf=1 and zero=1.
REQ-023 SHALL set flags to 0 for normal results; flags travel with their result.

Reset
REQ-024 SHALL, while reset_n=0, clear all stage valid bits; out_valid=0, in_ready=0, res=0, flags=0.
REQ-025 SHALL discard in-flight operations on a mid-stream reset; in_ready SHALL return to 1 on the first clock after reset_n rises.

Configuration
REQ-026 SHALL use the macro FP_MUL_ROUND_EN: when defined, round-to-nearest-even using guard and sticky bits; a mantissa carry-out increments e and is re-checked for overflow.
REQ-027 SHALL, when FP_MUL_ROUND_EN is undefined, truncate the discarded bits; latency is unchanged.

Structure
REQ-028 SHALL place the default EXP_W and MAN_W, a bias function, and a flags struct/index constants (FLAG_OVF=2, FLAG_UNF=1, FLAG_ZERO=0) in package fp_pkg.
REQ-029 SHALL instantiate the S3 normalise/round/pack logic as sub-module fp_norm_round (combinational, same parameters).

Verification (defaults EXP_W=8, MAN_W=18)
REQ-030 SHALL be tested with 0x1FE0000 x 0x1FE0000 (1.5x1.5): response 0x2008000 with flags=0, and 0x5FE0000 x 0x1FE0000: response 0x6008000, each arriving 3 cycles after accept.
REQ-031 SHALL be tested with 0x1FC0001 x 0x1FE0000 (tie case): response 0x1FE0002 with FP_MUL_ROUND_EN defined and 0x1FE0001 without it.
REQ-032 SHALL be tested with 0x3C00000 x 0x3C00000: response 0x3FFFFFF with ovf; and 0x0400000 x 0x0400000: response 0x0000000 with unf and zero.
REQ-033 SHALL be tested with 0x0000000 x 0x1FC0000: response 0x0000000 with zero=1; and 0x4000000 x 0x1FC0000: response 0x4000000 with zero=1.
REQ-034 SHALL be tested by streaming 6 back-to-back ops with out_ready low for cycles 4-6: in_ready falls once 3 ops are held, res stays stable during the stall, and all 6 results emerge in order with no loss.
REQ-035 SHALL be tested by asserting reset_n low with 2 ops in flight: out_valid=0 immediately, no stale result after release, and a new op completes in 3 cycles.
